// File: rtl/cpm_mac_acc.sv
// Signed multiply-accumulate stage: accepts Len activation/weight pairs, sums the
// products with saturation and hands the result downstream over a valid/ready handshake.
module cpm_mac_acc #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 24,
    parameter int unsigned LW = 8
) (
    input  logic          Clk,
    input  logic          Rstn,
    input  logic          Start,
    input  logic [LW-1:0] Len,
    input  logic          InVld,
    output logic          InRdy,
    input  logic [DW-1:0] ActIn,
    input  logic [DW-1:0] WeiIn,
    output logic          OutVld,
    input  logic          OutRdy,
    output logic [AW-1:0] AccOut,
    output logic          OutClr,
    output logic          Busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

    state_e state_q, state_d;

    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic            prod_vld_q, prod_vld_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            clr_q, clr_d;

    logic [2*DW-1:0] prod_full;
    logic [AW:0]     sum;
    logic [AW-1:0]   acc_sat;
    logic            last_pair;

    assign prod_full = $signed(ActIn) * $signed(WeiIn);

    // One guard bit above the accumulator makes overflow visible as a sign-bit disagreement.
    assign sum = {{(AW + 1 - 2 * DW){prod_q[2*DW-1]}}, prod_q} + {acc_q[AW-1], acc_q};

    always_comb begin
        acc_sat = sum[AW-1:0];
        if (sum[AW] != sum[AW-1]) begin
            acc_sat = sum[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
        end
    end

    // Only evaluated in RUN, where len_q is known to be non-zero.
    assign last_pair = (cnt_q == len_q - LW'(1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        clr_d      = 1'b0;
        InRdy      = 1'b0;
        OutVld     = 1'b0;

        if (prod_vld_q) begin
            acc_d = acc_sat;
        end

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    len_d   = Len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    clr_d   = 1'b1;
                    state_d = (Len == '0) ? StOut : StRun;
                end
            end
            StRun: begin
                InRdy = 1'b1;
                if (InVld) begin
                    prod_d     = prod_full;
                    prod_vld_d = 1'b1;
                    cnt_d      = cnt_q + LW'(1);
                    if (last_pair) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!prod_vld_q) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                OutVld = 1'b1;
                if (OutRdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            clr_q      <= clr_d;
        end
    end

    assign AccOut = acc_q;
    assign OutClr = clr_q;
    assign Busy   = (state_q != StIdle);

endmodule
